// File: rtl/countdown_timer.sv
// Loadable countdown timer: captures a value on load, decrements once every TICK_DIV enabled cycles, flags done at zero.
// Latency: load visible 1 cycle after the load edge; all outputs registered. No backpressure; en=0 freezes the count.
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             tick
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_count;
    logic             r_running;
    logic             r_done;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_count   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            // Load overrides everything, including a coinciding terminal prescale edge.
            if (load) begin
                r_count <= value;
                r_pre   <= '0;
                if (value != '0) begin
                    r_state   <= S_RUN;
                    r_running <= 1'b1;
                    r_done    <= 1'b0;
                end else begin
                    r_state   <= S_DONE;
                    r_running <= 1'b0;
                    r_done    <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (en) begin
                            if (r_pre == PRE_LAST) begin
                                r_pre   <= '0;
                                r_count <= r_count - CNT_ONE;
                                r_tick  <= 1'b1;
                                if (r_count == CNT_ONE) begin
                                    r_state   <= S_DONE;
                                    r_running <= 1'b0;
                                    r_done    <= 1'b1;
                                end
                            end else begin
                                r_pre <= r_pre + PRE_ONE;
                            end
                        end
                    end
                    default: begin
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign done    = r_done;
    assign tick    = r_tick;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (WIDTH=8, TICK_DIV=4): per-cycle scoreboard plus directed scenario checks.
module tb_countdown_timer;

    localparam int W  = 8;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [W-1:0] value;
    logic         en;
    logic [W-1:0] count;
    logic         running;
    logic         done;
    logic         tick;

    countdown_timer #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .value   (value),
        .en      (en),
        .count   (count),
        .running (running),
        .done    (done),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         run;
        logic         dn;
        logic         tk;
    } exp_t;

    exp_t q[$];

    int n_total = 0;
    int n_bad   = 0;
    int n_ticks = 0;

    // Reference model: 0=idle, 1=run, 2=done
    int        m_st  = 0;
    int        m_pre = 0;
    int        m_cnt = 0;
    logic      m_tk  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_pre = 0;
        m_cnt = 0;
        m_tk  = 1'b0;
    endtask

    // Advance the model by one edge from the currently driven inputs, push the
    // expectation, clock the DUT and compare once its outputs have settled.
    task automatic step(input string tag);
        exp_t e;
        exp_t g;
        m_tk = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (load) begin
            m_cnt = int'(value);
            m_pre = 0;
            m_st  = (value == 0) ? 2 : 1;
        end else if (m_st == 1 && en) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                m_cnt = m_cnt - 1;
                m_tk  = 1'b1;
                if (m_cnt == 0) m_st = 2;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        e.cnt = W'(m_cnt);
        e.run = (m_st == 1);
        e.dn  = (m_st == 2);
        e.tk  = m_tk;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk({tag, ".count"},   32'(count),   32'(g.cnt));
        chk({tag, ".running"}, 32'(running), 32'(g.run));
        chk({tag, ".done"},    32'(done),    32'(g.dn));
        chk({tag, ".tick"},    32'(tick),    32'(g.tk));
        if (tick === 1'b1) n_ticks++;
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        en    = 1'b0;
        #2;
        chk("rst.count",   32'(count),   32'd0);
        chk("rst.running", 32'(running), 32'd0);
        chk("rst.done",    32'(done),    32'd0);
        chk("rst.tick",    32'(tick),    32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: load 3, count down at 4-cycle spacing
        load = 1'b1; value = 8'd3; en = 1'b1;
        step("t1.load");
        load = 1'b0;
        chk("t1.cnt3", 32'(count), 32'd3);
        chk("t1.run",  32'(running), 32'd1);
        n_ticks = 0;
        steps("t1.a", 4);
        chk("t1.cnt2", 32'(count), 32'd2);
        steps("t1.b", 4);
        chk("t1.cnt1", 32'(count), 32'd1);
        steps("t1.c", 4);
        chk("t1.cnt0", 32'(count), 32'd0);
        chk("t1.done", 32'(done),  32'd1);
        steps("t1.d", 3);
        chk("t1.ticks", 32'(n_ticks), 32'd3);

        // 2: load zero goes straight to done
        n_ticks = 0;
        load = 1'b1; value = 8'd0;
        step("t2.load");
        load = 1'b0;
        chk("t2.done", 32'(done),    32'd1);
        chk("t2.run",  32'(running), 32'd0);
        steps("t2.hold", 8);
        chk("t2.ticks", 32'(n_ticks), 32'd0);

        // 3: pause mid-prescale, resume continues the partial prescale
        load = 1'b1; value = 8'd5;
        step("t3.load");
        load = 1'b0;
        steps("t3.pre", 2);
        en = 1'b0;
        n_ticks = 0;
        steps("t3.pause", 10);
        chk("t3.frozen", 32'(count), 32'd5);
        chk("t3.noTick", 32'(n_ticks), 32'd0);
        en = 1'b1;
        step("t3.res1");
        chk("t3.still5", 32'(count), 32'd5);
        step("t3.res2");
        chk("t3.cnt4", 32'(count), 32'd4);
        chk("t3.tick", 32'(tick),  32'd1);

        // 4: load FF on the terminal prescale edge at count 2
        steps("t4.toCnt2", 8);
        chk("t4.cnt2", 32'(count), 32'd2);
        steps("t4.pre", 3);
        load = 1'b1; value = 8'hFF;
        step("t4.load");
        load = 1'b0;
        chk("t4.ff",    32'(count), 32'hFF);
        chk("t4.noTk",  32'(tick),  32'd0);
        steps("t4.restart", 3);
        chk("t4.ffHeld", 32'(count), 32'hFF);
        step("t4.dec");
        chk("t4.fe", 32'(count), 32'hFE);

        // 5: async reset mid-run
        steps("t5.run", 2);
        #3 rst_n = 1'b0;
        #1;
        chk("t5.count",   32'(count),   32'd0);
        chk("t5.running", 32'(running), 32'd0);
        chk("t5.done",    32'(done),    32'd0);
        chk("t5.tick",    32'(tick),    32'd0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_ticks = 0;
        steps("t5.idle", 6);
        chk("t5.idleRun", 32'(running), 32'd0);
        chk("t5.idleTk",  32'(n_ticks), 32'd0);

        // 6: done ignores en, then reload
        load = 1'b1; value = 8'd1;
        step("t6.load");
        load = 1'b0;
        steps("t6.run", 4);
        chk("t6.done", 32'(done), 32'd1);
        for (int i = 0; i < 20; i++) begin
            en = ~en;
            step("t6.tog");
        end
        chk("t6.cnt0",  32'(count), 32'd0);
        chk("t6.done2", 32'(done),  32'd1);
        en = 1'b1;
        load = 1'b1; value = 8'd2;
        step("t6.reload");
        load = 1'b0;
        chk("t6.run2", 32'(running), 32'd1);
        chk("t6.cnt2", 32'(count),   32'd2);
        steps("t6.tail", 9);
        chk("t6.end", 32'(done), 32'd1);

        chk("q.empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
